// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } spi_target_state_e;

endpackage

// File: rtl/spi_target_if.sv
// SPI pins plus the local rx/tx byte handshake of the SPI target.
// SPI_TARGET_MISO_OE_EN adds the spi_miso_oe output.
interface spi_target_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
);

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
`ifdef SPI_TARGET_MISO_OE_EN
  logic              spi_miso_oe;
`endif

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
    input  spi_miso, tx_ready, rx_data, rx_valid, tx_underrun
`ifdef SPI_TARGET_MISO_OE_EN
    , input spi_miso_oe
`endif
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, tx_ready, rx_data, rx_valid, tx_underrun
`ifdef SPI_TARGET_MISO_OE_EN
    , output spi_miso_oe
`endif
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer followed by one edge-detect register.
// level_o, rise_o and fall_o are all registered and mutually aligned.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_i};
      level_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_target.sv
// Mode-0, MSB-first SPI target with a one-byte transmit buffer.
// Optional macro SPI_TARGET_MISO_OE_EN adds spi_miso_oe and gates spi_miso with it.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  spi_target_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .in_i   (bus.spi_sclk),
    .level_o(sclk_level),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // CS_n idles high, so its synchronizer resets high to avoid a false cs_fall.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .in_i   (bus.spi_cs_n),
    .level_o(cs_level),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst    (rst),
    .in_i   (bus.spi_mosi),
    .level_o(mosi),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  assign unused_edges = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

  spi_target_state_e state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic              byte_done_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] buf_q;
  logic              full_q;
  logic              miso_q;
  logic              rx_valid_q;
  logic              underrun_q;

  logic              buf_wr;
  logic              buf_load;
  logic [DATA_W-1:0] rx_next;

  assign buf_wr   = bus.tx_valid & ~full_q;
  // Load at frame start, or on the falling SCLK that follows a completed byte.
  assign buf_load = (state_q == StIdle) ? cs_fall :
                    (~cs_rise & sclk_fall & (bit_cnt_q == '0) & byte_done_q);
  assign rx_next  = {rx_shift_q[DATA_W-2:0], mosi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      buf_q       <= '0;
      full_q      <= 1'b0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (buf_wr) buf_q <= bus.tx_data;
      full_q <= buf_wr | (full_q & ~buf_load);
      if (buf_load) begin
        tx_shift_q <= full_q ? buf_q : '0;
        miso_q     <= full_q & buf_q[DATA_W-1];
        if (!full_q) underrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q     <= StShift;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
          end
        end
        StShift: begin
          if (cs_rise) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_next;
            if (bit_cnt_q == LastBit) begin
              rx_data_q   <= rx_next;
              rx_valid_q  <= 1'b1;
              bit_cnt_q   <= '0;
              byte_done_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt_q != '0) begin
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
              miso_q     <= tx_shift_q[DATA_W-2];
            end else if (byte_done_q) begin
              byte_done_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_ready    = ~full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;

`ifdef SPI_TARGET_MISO_OE_EN
  assign bus.spi_miso_oe = (state_q == StShift);
  assign bus.spi_miso    = miso_q & (state_q == StShift);
`else
  assign bus.spi_miso    = miso_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target against a cycle-scheduled transaction model.
module tb_spi_target;

  localparam int Sync = 2;
  localparam int Lat  = Sync + 2;  // pin edge to visible effect, in clk cycles
  localparam int Half = 4;         // half SCLK period: SCLK = clk/8

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_target_if #(.DATA_W(8)) bus ();

  spi_target #(.DATA_W(8), .SYNC_STAGES(Sync)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rxv_cnt = 0;

  // Transaction model: scheduled effects keyed by the cycle they become visible.
  bit         s_load [int];
  logic [7:0] s_wr   [int];
  logic [7:0] s_rx   [int];
  bit         s_oe   [int];
  logic [7:0] m_txq  [$];
  bit         m_full, m_underrun, m_rx_valid, m_oe;
  logic [7:0] m_buf, m_rx_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    s_load.delete();
    s_wr.delete();
    s_rx.delete();
    s_oe.delete();
    m_txq.delete();
    m_full = 0; m_underrun = 0; m_rx_valid = 0; m_oe = 0;
    m_buf = 8'h00; m_rx_data = 8'h00;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_clear();
      end else begin
        m_rx_valid = 0;
        if (s_load.exists(cyc)) begin
          m_txq.push_back(m_full ? m_buf : 8'h00);
          if (!m_full) m_underrun = 1;
          m_full = 0;
          s_load.delete(cyc);
        end
        if (s_wr.exists(cyc)) begin
          m_buf  = s_wr[cyc];
          m_full = 1;
          s_wr.delete(cyc);
        end
        if (s_rx.exists(cyc)) begin
          m_rx_valid = 1;
          m_rx_data  = s_rx[cyc];
          s_rx.delete(cyc);
        end
        if (s_oe.exists(cyc)) begin
          m_oe = s_oe[cyc];
          s_oe.delete(cyc);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) rxv_cnt++;
      chk("rx_valid", bus.rx_valid, m_rx_valid);
      chk("rx_data", bus.rx_data, m_rx_data);
      chk("tx_ready", bus.tx_ready, !m_full);
      chk("tx_underrun", bus.tx_underrun, m_underrun);
      if (rst) chk("miso_in_reset", bus.spi_miso, 1'b0);
`ifdef SPI_TARGET_MISO_OE_EN
      chk("miso_oe", bus.spi_miso_oe, m_oe);
      if (!m_oe) chk("miso_gated", bus.spi_miso, 1'b0);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic buf_write(input logic [7:0] d);
    int waited = 0;
    while (m_full && waited < 200) begin
      tick(1);
      waited++;
    end
    if (m_full) begin
      chk("buf_write_wait", 32'd1, 32'd0);
    end else begin
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      s_wr[cyc+1]  = d;
      tick(1);
      bus.tx_valid = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    s_load[cyc+Lat] = 1;
    s_oe[cyc+Lat]   = 1;
  endtask

  // end_mode: 0 keep CS low (back-to-back), 1 SCLK fall with CS rise, 2 leave pins as is
  task automatic xfer(input logic [7:0] mo, input int nbits, input int end_mode,
                      output logic [7:0] got, output logic [7:0] exp_tx);
    got = 8'h00;
    exp_tx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = mo[7-i];
      tick(Half);
      if (i == 0) begin
        if (m_txq.size() == 0) chk("tx_byte_loaded", 32'd0, 32'd1);
        else exp_tx = m_txq.pop_front();
`ifdef SPI_TARGET_MISO_OE_EN
        chk("oe_in_frame", bus.spi_miso_oe, 1'b1);
`endif
      end
      got[7-i] = bus.spi_miso;
      chk("miso_bit", bus.spi_miso, exp_tx[7-i]);
      bus.spi_sclk = 1'b1;
      if (i == 7) s_rx[cyc+Lat] = mo;
      tick(Half);
      if (i < nbits - 1) bus.spi_sclk = 1'b0;
    end
    if (end_mode == 0) begin
      bus.spi_sclk = 1'b0;
      s_load[cyc+Lat] = 1;
    end else if (end_mode == 1) begin
      bus.spi_sclk = 1'b0;
      bus.spi_cs_n = 1'b1;
      s_oe[cyc+Lat] = 0;
      tick(Half);
    end
  endtask

  task automatic do_reset(input bit pin_checks);
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    if (pin_checks) begin
      chk("rst_rx_data", bus.rx_data, 8'h00);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_tx_ready", bus.tx_ready, 1'b1);
      chk("rst_underrun", bus.tx_underrun, 1'b0);
      chk("rst_miso", bus.spi_miso, 1'b0);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0] got, ex, got2, ex2, rnd;
    int c0, nb;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    do_reset(1'b1);

    // Single frame: buffer 0xA5, initiator sends 0x3C.
`ifdef SPI_TARGET_MISO_OE_EN
    chk("oe_idle", bus.spi_miso_oe, 1'b0);
    chk("miso_idle_gated", bus.spi_miso, 1'b0);
`endif
    buf_write(8'hA5);
    c0 = rxv_cnt;
    cs_low();
    xfer(8'h3C, 8, 1, got, ex);
    tick(8);
    chk("t1_model_tx", ex, 8'hA5);
    chk("t1_miso_byte", got, 8'hA5);
    chk("t1_rx_data", bus.rx_data, 8'h3C);
    chk("t1_rx_pulses", rxv_cnt - c0, 1);
    chk("t1_underrun", bus.tx_underrun, 1'b0);
    chk("t1_tx_ready", bus.tx_ready, 1'b1);

    // Back-to-back frames, second byte buffered during the first.
    buf_write(8'h11);
    c0 = rxv_cnt;
    cs_low();
    fork
      xfer(8'hF0, 8, 0, got, ex);
      begin tick(12); buf_write(8'h22); end
    join
    xfer(8'h0F, 8, 1, got2, ex2);
    tick(8);
    chk("t2_miso_byte1", got, 8'h11);
    chk("t2_miso_byte2", got2, 8'h22);
    chk("t2_rx_pulses", rxv_cnt - c0, 2);
    chk("t2_rx_data", bus.rx_data, 8'h0F);
    chk("t2_underrun", bus.tx_underrun, 1'b0);

    // Empty buffer at frame start.
    cs_low();
    xfer(8'h55, 8, 1, got, ex);
    tick(4);
    chk("t3_miso_zero", got, 8'h00);
    chk("t3_underrun", bus.tx_underrun, 1'b1);
    buf_write(8'h77);
    cs_low();
    xfer(8'h9E, 8, 1, got, ex);
    tick(4);
    chk("t3_good_miso", got, 8'h77);
    chk("t3_sticky", bus.tx_underrun, 1'b1);

    // Frame aborted after 5 bits, then a full frame.
    buf_write(8'h12);
    c0 = rxv_cnt;
    cs_low();
    xfer(8'hC3, 5, 1, got, ex);
    tick(8);
    chk("t4_no_pulse", rxv_cnt - c0, 0);
    chk("t4_rx_kept", bus.rx_data, 8'h9E);
    buf_write(8'h34);
    cs_low();
    xfer(8'h81, 8, 1, got, ex);
    tick(6);
    chk("t4_rx_data", bus.rx_data, 8'h81);
    chk("t4_miso_byte", got, 8'h34);

    // Reset after 3 bits, then a clean frame.
    buf_write(8'h56);
    cs_low();
    xfer(8'hE7, 3, 2, got, ex);
    do_reset(1'b1);
    buf_write(8'h9C);
    cs_low();
    xfer(8'h5A, 8, 1, got, ex);
    tick(6);
    chk("t5_rx_data", bus.rx_data, 8'h5A);
    chk("t5_miso_byte", got, 8'h9C);
    chk("t5_underrun", bus.tx_underrun, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) != 0 && !m_full) buf_write(8'($urandom));
      cs_low();
      if ($urandom_range(0, 4) == 0) begin
        xfer(8'($urandom), $urandom_range(1, 7), 1, got, ex);
      end else begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          rnd = 8'($urandom);
          fork
            xfer(rnd, 8, (b == nb - 1) ? 1 : 0, got, ex);
            begin
              if ($urandom_range(0, 1) == 1) begin
                tick($urandom_range(2, 20));
                if (!m_full) buf_write(8'($urandom));
              end
            end
          join
        end
      end
      tick($urandom_range(1, 6));
    end
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
